// File: rtl/tlx_credit_mgr_if.sv
// tlx_credit_mgr_if: TLX credit manager bus; master drives link/requests, slave is the manager.
interface tlx_credit_mgr_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 7
);
  logic                    tlx_afu_ready;
  logic [NUM_CH*CNT_W-1:0] init_credit;
  logic [NUM_CH-1:0]       credit_return;
  logic [NUM_CH-1:0]       cons_req;
  logic [NUM_CH*3-1:0]     cons_amt;
  logic [NUM_CH-1:0]       cons_gnt;
  logic [NUM_CH*CNT_W-1:0] credit_avail;
  logic                    mgr_ready;
  logic [NUM_CH-1:0]       credit_ovf_err;
  modport master (
    output tlx_afu_ready, init_credit, credit_return, cons_req, cons_amt,
    input  cons_gnt, credit_avail, mgr_ready, credit_ovf_err
  );
  modport slave (
    input  tlx_afu_ready, init_credit, credit_return, cons_req, cons_amt,
    output cons_gnt, credit_avail, mgr_ready, credit_ovf_err
  );
endinterface

// File: rtl/tlx_credit_mgr.sv
// tlx_credit_mgr: per-channel TLX credit counters with IDLE/LOAD/RUN link sequencing.
// Define TLX_CREDIT_OVF_CHK_EN to saturate on overflow and flag credit_ovf_err; otherwise counters wrap.
module tlx_credit_mgr #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 7
) (
  input logic             afu_clock,
  input logic             afu_reset_n,
  tlx_credit_mgr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;
  state_e state, state_nxt;
  logic run;
  logic [NUM_CH-1:0] gnt;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] nxt [NUM_CH];
  always_ff @(posedge afu_clock)
    state <= !afu_reset_n ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (bus.tlx_afu_ready ? LOAD : IDLE) :
                state == LOAD ? RUN :
                (bus.tlx_afu_ready ? RUN : IDLE);
  end
  assign run           = state == RUN;
  assign bus.mgr_ready = run;
  assign bus.cons_gnt  = gnt;
`ifdef TLX_CREDIT_OVF_CHK_EN
  logic [NUM_CH-1:0] ovf, ovf_set;
`endif
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [2:0]     amt;
    logic [CNT_W:0] sum;
    assign amt    = bus.cons_amt[i*3 +: 3];
    assign gnt[i] = run & bus.cons_req[i] & (amt <= 3'd4) & (CNT_W'(amt) <= cnt[i]);
    // A grant never exceeds the pre-update count, so sum cannot underflow.
    assign sum = {1'b0, cnt[i]} + (CNT_W+1)'(bus.credit_return[i])
               - (gnt[i] ? (CNT_W+1)'(amt) : '0);
`ifdef TLX_CREDIT_OVF_CHK_EN
    assign nxt[i]     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    assign ovf_set[i] = run & bus.tlx_afu_ready & sum[CNT_W];
`else
    logic unused_carry;
    assign unused_carry = sum[CNT_W];
    assign nxt[i]       = sum[CNT_W-1:0];
`endif
    assign bus.credit_avail[i*CNT_W +: CNT_W] = cnt[i];
  end
  always_ff @(posedge afu_clock)
    for (int j = 0; j < NUM_CH; j++)
      cnt[j] <= !afu_reset_n ? '0 :
                state == LOAD ? bus.init_credit[j*CNT_W +: CNT_W] :
                (run && bus.tlx_afu_ready) ? nxt[j] : '0;
`ifdef TLX_CREDIT_OVF_CHK_EN
  always_ff @(posedge afu_clock)
    ovf <= !afu_reset_n ? '0 : ovf | ovf_set;
  assign bus.credit_ovf_err = ovf;
`else
  assign bus.credit_ovf_err = '0;
`endif
endmodule

// File: tb/tb_tlx_credit_mgr.sv
// tb_tlx_credit_mgr: directed corner cases plus random traffic against a credit-accounting model.
module tb_tlx_credit_mgr;
  localparam int NC = 4, W = 7, MAXC = (1 << W) - 1;
  logic clk = 0, rst_n = 0;
  int errors = 0, checks = 0;
  int cnt[NC];
  bit ovf[NC];
  int st;
  tlx_credit_mgr_if #(.NUM_CH(NC), .CNT_W(W)) bus ();
  tlx_credit_mgr #(.NUM_CH(NC), .CNT_W(W)) dut (.afu_clock(clk), .afu_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_amt(input int ch, input int v);
    bus.cons_amt[ch*3 +: 3] = 3'(v);
  endtask
  // st: 0 idle, 1 loading, 2 running
  task automatic cycle();
    logic [NC-1:0] eg, eo;
    logic [NC*W-1:0] ea;
    int a, n;
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      a = int'(bus.cons_amt[i*3 +: 3]);
      eg[i] = st == 2 && bus.cons_req[i] && a <= 4 && cnt[i] >= a;
      ea[i*W +: W] = W'(cnt[i]);
      eo[i] = ovf[i];
    end
    check("mgr_ready", bus.mgr_ready, st == 2);
    check("cons_gnt", bus.cons_gnt, eg);
    check("credit_avail", bus.credit_avail, ea);
    check("ovf_err", bus.credit_ovf_err, eo);
    @(posedge clk);
    if (!rst_n) begin
      st = 0;
      for (int i = 0; i < NC; i++) begin cnt[i] = 0; ovf[i] = 0; end
    end else if (st == 0) st = bus.tlx_afu_ready ? 1 : 0;
    else if (st == 1) begin
      for (int i = 0; i < NC; i++) cnt[i] = int'(bus.init_credit[i*W +: W]);
      st = 2;
    end else if (!bus.tlx_afu_ready) begin
      st = 0;
      for (int i = 0; i < NC; i++) cnt[i] = 0;
    end else
      for (int i = 0; i < NC; i++) begin
        a = int'(bus.cons_amt[i*3 +: 3]);
        n = cnt[i] + int'(bus.credit_return[i]) - (eg[i] ? a : 0);
`ifdef TLX_CREDIT_OVF_CHK_EN
        if (n > MAXC) begin n = MAXC; ovf[i] = 1; end
`else
        n = n % (MAXC + 1);
`endif
        cnt[i] = n;
      end
    #1;
  endtask
  initial begin
    st = 0;
    for (int i = 0; i < NC; i++) begin cnt[i] = 0; ovf[i] = 0; end
    bus.tlx_afu_ready = 0; bus.init_credit = '0; bus.credit_return = '0;
    bus.cons_req = '0; bus.cons_amt = '0;
    cycle(); cycle();
    check("reset_ready", bus.mgr_ready, 0);
    check("reset_avail", bus.credit_avail, 0);
    rst_n = 1; bus.tlx_afu_ready = 1;
    bus.init_credit = {7'd10, 7'd2, 7'd3, 7'd8};
    cycle(); cycle();
    check("ready_2cyc", bus.mgr_ready, 1);
    check("ch0_init", bus.credit_avail[0 +: W], 8);
    bus.cons_req = 4'b0010; set_amt(1, 4); #1;
    check("ch1_amt4_gnt", bus.cons_gnt[1], 0);
    cycle();
    check("ch1_amt4_cnt", bus.credit_avail[W +: W], 3);
    set_amt(1, 3); #1;
    check("ch1_amt3_gnt", bus.cons_gnt[1], 1);
    cycle();
    check("ch1_amt3_cnt", bus.credit_avail[W +: W], 0);
    bus.cons_req = 4'b0100; bus.credit_return = 4'b0100; set_amt(2, 2); #1;
    check("ch2_ret_gnt", bus.cons_gnt[2], 1);
    cycle();
    check("ch2_ret_cnt", bus.credit_avail[2*W +: W], 1);
    bus.credit_return = '0; bus.cons_req = 4'b1000; set_amt(3, 6); #1;
    check("ch3_amt6_gnt", bus.cons_gnt[3], 0);
    cycle();
    check("ch3_amt6_cnt", bus.credit_avail[3*W +: W], 10);
    bus.cons_req = '0; bus.tlx_afu_ready = 0;
    cycle();
    bus.tlx_afu_ready = 1; bus.init_credit = {4{7'd5}};
    cycle(); cycle();
    check("ch0_five", bus.credit_avail[0 +: W], 5);
    bus.cons_req = 4'b1111; bus.cons_amt = {4{3'd1}}; bus.tlx_afu_ready = 0;
    cycle();
    check("drop_ready", bus.mgr_ready, 0);
    check("drop_avail", bus.credit_avail, 0);
    check("drop_gnt", bus.cons_gnt, 0);
    bus.cons_req = '0; bus.tlx_afu_ready = 1; bus.init_credit = {21'd0, 7'd127};
    cycle(); cycle();
    bus.credit_return = 4'b0001;
    cycle();
    bus.credit_return = '0;
`ifdef TLX_CREDIT_OVF_CHK_EN
    check("ovf_cnt", bus.credit_avail[0 +: W], 127);
    check("ovf_flag", bus.credit_ovf_err, 4'b0001);
`else
    check("wrap_cnt", bus.credit_avail[0 +: W], 0);
    check("wrap_flag", bus.credit_ovf_err, 0);
`endif
    bus.tlx_afu_ready = 0;
    cycle();
    bus.tlx_afu_ready = 1;
    cycle();
    rst_n = 0;
    cycle();
    check("rst_load_ready", bus.mgr_ready, 0);
    check("rst_load_avail", bus.credit_avail, 0);
    check("rst_load_ovf", bus.credit_ovf_err, 0);
    rst_n = 1; bus.tlx_afu_ready = 0; bus.cons_req = 4'b1111; bus.cons_amt = '0;
    cycle();
    check("idle_gnt", bus.cons_gnt, 0);
    for (int k = 0; k < 3000; k++) begin
      rst_n = $urandom_range(199) != 0;
      bus.tlx_afu_ready = $urandom_range(39) != 0;
      bus.init_credit = (NC*W)'($urandom);
      bus.credit_return = NC'($urandom);
      bus.cons_req = NC'($urandom);
      bus.cons_amt = (NC*3)'($urandom);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
